// File: rtl/sparse_syndrome_gen_if.sv
// rtl/sparse_syndrome_gen_if.sv - request/result bundle for the sparse syndrome generator
interface sparse_syndrome_gen_if #(
    parameter int R     = 127,
    parameter int W     = 5,
    parameter int POS_W = 8
) ();
    logic                 start;
    logic [R-1:0]         c0_in;
    logic [R-1:0]         c1_in;
    logic [W*POS_W-1:0]   h0_pos_flat;
    logic [W*POS_W-1:0]   h1_pos_flat;
    logic [R-1:0]         s_out;
    logic                 s_zero;
    logic                 busy;
    logic                 done;
    logic                 pos_err;

    // Requester side: issues start with operands, observes the result.
    modport master (
        output start, c0_in, c1_in, h0_pos_flat, h1_pos_flat,
        input  s_out, s_zero, busy, done, pos_err
    );

    // Generator side.
    modport slave (
        input  start, c0_in, c1_in, h0_pos_flat, h1_pos_flat,
        output s_out, s_zero, busy, done, pos_err
    );
endinterface

// File: rtl/sparse_syndrome_gen.sv
// rtl/sparse_syndrome_gen.sv - sparse cyclic syndrome s = c0*h0 (+ c1*h1 with SYND_DUAL_EN)
module sparse_syndrome_gen #(
    parameter int R     = 127,
    parameter int W     = 5,
    parameter int POS_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    sparse_syndrome_gen_if.slave  bus
);
    localparam int K_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(W - 1);

    typedef enum logic [1:0] {IDLE, LOAD, ACC, DONE} state_t;

    state_t             state;
    logic [R-1:0]       c0_q;
    logic [R-1:0]       c1_q;
    logic [W*POS_W-1:0] h0_q;
    logic [W*POS_W-1:0] h1_q;
    logic [R-1:0]       acc;
    logic [K_W-1:0]     k;
    logic [R-1:0]       s_q;
    logic               s_zero_q;
    logic               done_q;
    logic               pos_err_q;

    logic [POS_W-1:0]   pos0;
    logic [POS_W-1:0]   pos1;
    logic               any_bad;
    logic [R-1:0]       acc_next;

    // Rotate left by p (p < R): the upper half of the doubled vector shifted by p
    // is exactly the cyclic rotation, so no modulo is needed.
    function automatic logic [R-1:0] rotl(input logic [R-1:0] x, input logic [POS_W-1:0] p);
        logic [2*R-1:0] d;
        d = {x, x} << p;
        return d[2*R-1:R];
    endfunction

    function automatic logic out_of_range(input logic [POS_W-1:0] p);
        return 32'(p) >= 32'(R);
    endfunction

    // Pick the position pair for the current accumulation index.
    always_comb begin
        pos0 = '0;
        pos1 = '0;
        for (int i = 0; i < W; i++) begin
            if (K_W'(i) == k) begin
                pos0 = h0_q[i*POS_W +: POS_W];
                pos1 = h1_q[i*POS_W +: POS_W];
            end
        end
    end

    // Range check of all registered positions, used in LOAD.
    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (out_of_range(h0_q[i*POS_W +: POS_W])) any_bad = 1'b1;
`ifdef SYND_DUAL_EN
            if (out_of_range(h1_q[i*POS_W +: POS_W])) any_bad = 1'b1;
`endif
        end
    end

`ifdef SYND_DUAL_EN
    // One rotated term from each parity block per cycle.
    always_comb begin
        acc_next = acc ^ rotl(c0_q, pos0) ^ rotl(c1_q, pos1);
    end
`else
    // Single block: the second operand is captured but has no effect.
    logic unused_dual;
    assign unused_dual = ^{c1_q, pos1};

    // One rotated term per cycle.
    always_comb begin
        acc_next = acc ^ rotl(c0_q, pos0);
    end
`endif

    // Control FSM with registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            c0_q      <= '0;
            c1_q      <= '0;
            h0_q      <= '0;
            h1_q      <= '0;
            acc       <= '0;
            k         <= '0;
            s_q       <= '0;
            s_zero_q  <= 1'b0;
            done_q    <= 1'b0;
            pos_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q   <= 1'b0;
                    s_zero_q <= 1'b0;
                    if (bus.start) begin
                        c0_q      <= bus.c0_in;
                        c1_q      <= bus.c1_in;
                        h0_q      <= bus.h0_pos_flat;
                        h1_q      <= bus.h1_pos_flat;
                        acc       <= '0;
                        k         <= '0;
                        pos_err_q <= 1'b0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (any_bad) begin
                        pos_err_q <= 1'b1;
                        s_q       <= '0;
                        s_zero_q  <= 1'b1;
                        done_q    <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state     <= ACC;
                    end
                end
                ACC: begin
                    acc <= acc_next;
                    if (k == K_LAST) begin
                        s_q      <= acc_next;
                        s_zero_q <= (acc_next == '0);
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end else begin
                        k <= k + K_W'(1);
                    end
                end
                DONE: begin
                    // Result holds; a start still high from the last request must drop first.
                    if (!bus.start) begin
                        done_q   <= 1'b0;
                        s_zero_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s_out   = s_q;
    assign bus.s_zero  = s_zero_q;
    assign bus.done    = done_q;
    assign bus.pos_err = pos_err_q;
    assign bus.busy    = (state == LOAD) || (state == ACC);
endmodule

// File: tb/tb_sparse_syndrome_gen.sv
// tb/tb_sparse_syndrome_gen.sv - self-checking bench for sparse_syndrome_gen (R=5, W=3)
module tb_sparse_syndrome_gen;
    localparam int R     = 5;
    localparam int W     = 3;
    localparam int POS_W = 4;

    logic clk;
    logic rst;

    sparse_syndrome_gen_if #(.R(R), .W(W), .POS_W(POS_W)) bus ();

    sparse_syndrome_gen #(.R(R), .W(W), .POS_W(POS_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: cyclic polynomial product by sparse position lists.
    // Input bit i shifted by p lands at output bit (i+p) mod R.
    function automatic logic [5:0] ref_model(input logic [4:0] c0, input logic [4:0] c1,
                                             input logic [11:0] h0f, input logic [11:0] h1f);
        int h0 [3];
        int h1 [3];
        logic [4:0] s;
        logic err;
        s = '0;
        err = 1'b0;
        for (int j = 0; j < W; j++) begin
            h0[j] = int'(h0f[j*POS_W +: POS_W]);
            h1[j] = int'(h1f[j*POS_W +: POS_W]);
            if (h0[j] >= R) err = 1'b1;
`ifdef SYND_DUAL_EN
            if (h1[j] >= R) err = 1'b1;
`endif
        end
        if (!err) begin
            for (int j = 0; j < W; j++) begin
                for (int i = 0; i < R; i++) begin
                    if (c0[i]) s[(i + h0[j]) % R] ^= 1'b1;
`ifdef SYND_DUAL_EN
                    if (c1[i]) s[(i + h1[j]) % R] ^= 1'b1;
`endif
                end
            end
        end
        return {err, s};
    endfunction

    // One complete request: latency counted with the sampling edge as edge 1.
    task automatic run(input logic [4:0] c0, input logic [4:0] c1,
                       input logic [11:0] h0f, input logic [11:0] h1f,
                       input logic [4:0] exp_s, input logic exp_err, input string tag);
        int edges;
        @(negedge clk);
        bus.c0_in       = c0;
        bus.c1_in       = c1;
        bus.h0_pos_flat = h0f;
        bus.h1_pos_flat = h1f;
        bus.start       = 1'b1;
        @(posedge clk);
        edges = 1;
        #1;
        check({tag, " busy_after_start"}, 32'(bus.busy), 32'd1);
        bus.start       = 1'b0;
        bus.c0_in       = 5'($urandom);
        bus.h0_pos_flat = 12'($urandom);
        while (!bus.done && edges < 40) begin
            @(posedge clk);
            edges++;
            #1;
        end
        check({tag, " done"},    32'(bus.done), 32'd1);
        check({tag, " latency"}, 32'(edges), exp_err ? 32'd2 : 32'(W + 2));
        check({tag, " s_out"},   32'(bus.s_out), 32'(exp_s));
        check({tag, " pos_err"}, 32'(bus.pos_err), 32'(exp_err));
        check({tag, " s_zero"},  32'(bus.s_zero), 32'(exp_s == 5'd0));
        check({tag, " busy_done"}, 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, " done_clear"}, 32'(bus.done), 32'd0);
        check({tag, " s_hold"},     32'(bus.s_out), 32'(exp_s));
        check({tag, " err_hold"},   32'(bus.pos_err), 32'(exp_err));
    endtask

    typedef struct packed {
        logic [4:0]  c0;
        logic [4:0]  c1;
        logic [11:0] h0f;
        logic [11:0] h1f;
        logic [4:0]  exp_s;
        logic        exp_err;
    } vec_t;

    vec_t vecs [4];

    initial begin
        bus.start       = 1'b0;
        bus.c0_in       = '0;
        bus.c1_in       = '0;
        bus.h0_pos_flat = '0;
        bus.h1_pos_flat = '0;
        rst = 1'b1;

        // Positions packed as {p2, p1, p0}.
        vecs[0] = '{c0: 5'b00001, c1: 5'b00000, h0f: {4'd4, 4'd1, 4'd0}, h1f: 12'h000,
                    exp_s: 5'b10011, exp_err: 1'b0};
`ifdef SYND_DUAL_EN
        vecs[1] = '{c0: 5'b01100, c1: 5'b00010, h0f: {4'd4, 4'd1, 4'd0}, h1f: {4'd3, 4'd2, 4'd1},
                    exp_s: 5'b01110, exp_err: 1'b0};
`else
        vecs[1] = '{c0: 5'b01100, c1: 5'b00010, h0f: {4'd4, 4'd1, 4'd0}, h1f: {4'd3, 4'd2, 4'd1},
                    exp_s: 5'b10010, exp_err: 1'b0};
`endif
        vecs[2] = '{c0: 5'b00001, c1: 5'b00000, h0f: {4'd3, 4'd2, 4'd2}, h1f: 12'h000,
                    exp_s: 5'b01000, exp_err: 1'b0};
        vecs[3] = '{c0: 5'b00001, c1: 5'b00000, h0f: {4'd1, 4'd5, 4'd0}, h1f: 12'h000,
                    exp_s: 5'b00000, exp_err: 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("reset s_out",   32'(bus.s_out), 32'd0);
        check("reset s_zero",  32'(bus.s_zero), 32'd0);
        check("reset done",    32'(bus.done), 32'd0);
        check("reset busy",    32'(bus.busy), 32'd0);
        check("reset pos_err", 32'(bus.pos_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            run(vecs[v].c0, vecs[v].c1, vecs[v].h0f, vecs[v].h1f,
                vecs[v].exp_s, vecs[v].exp_err, $sformatf("vec%0d", v));
        end

        // Randomized operands against the reference model; positions reach one past R-1.
        for (int n = 0; n < 20; n++) begin
            logic [4:0]  c0, c1;
            logic [11:0] h0f, h1f;
            logic [5:0]  r;
            c0 = 5'($urandom);
            c1 = 5'($urandom);
            for (int j = 0; j < W; j++) begin
                h0f[j*POS_W +: POS_W] = 4'($urandom_range(0, 5));
                h1f[j*POS_W +: POS_W] = 4'($urandom_range(0, 5));
            end
            r = ref_model(c0, c1, h0f, h1f);
            run(c0, c1, h0f, h1f, r[4:0], r[5], $sformatf("rnd%0d", n));
        end

        // Zero operand with start held high through DONE: no restart until start drops.
        begin
            int edges;
            @(negedge clk);
            bus.c0_in       = 5'b00000;
            bus.c1_in       = 5'b00000;
            bus.h0_pos_flat = {4'd4, 4'd1, 4'd0};
            bus.h1_pos_flat = 12'h000;
            bus.start       = 1'b1;
            edges = 0;
            while (!bus.done && edges < 40) begin
                @(posedge clk);
                edges++;
                #1;
            end
            check("hold done",   32'(bus.done), 32'd1);
            check("hold s_out",  32'(bus.s_out), 32'd0);
            check("hold s_zero", 32'(bus.s_zero), 32'd1);
            for (int i = 0; i < 3; i++) begin
                @(posedge clk);
                #1;
                check($sformatf("hold stay_done%0d", i), 32'(bus.done), 32'd1);
                check($sformatf("hold no_busy%0d", i),   32'(bus.busy), 32'd0);
            end
            @(negedge clk);
            bus.start = 1'b0;
            @(posedge clk);
            #1;
            check("hold released done",   32'(bus.done), 32'd0);
            check("hold released s_zero", 32'(bus.s_zero), 32'd0);
            @(posedge clk);
            #1;
            check("hold idle busy", 32'(bus.busy), 32'd0);
        end

        // Reset during ACC aborts with nothing visible, then a fresh request completes.
        run(vecs[0].c0, vecs[0].c1, vecs[0].h0f, vecs[0].h1f, vecs[0].exp_s, 1'b0, "pre_rst");
        @(negedge clk);
        bus.c0_in       = vecs[0].c0;
        bus.c1_in       = vecs[0].c1;
        bus.h0_pos_flat = vecs[0].h0f;
        bus.h1_pos_flat = vecs[0].h1f;
        bus.start       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("abort in_acc busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort s_out",   32'(bus.s_out), 32'd0);
        check("abort done",    32'(bus.done), 32'd0);
        check("abort busy",    32'(bus.busy), 32'd0);
        check("abort pos_err", 32'(bus.pos_err), 32'd0);
        check("abort s_zero",  32'(bus.s_zero), 32'd0);
        @(posedge clk);
        #1;
        check("abort stays idle", 32'(bus.done | bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run(vecs[0].c0, vecs[0].c1, vecs[0].h0f, vecs[0].h1f, vecs[0].exp_s, 1'b0, "post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sparse_syndrome_gen.md
SPARSE_SYNDROME_GEN -- requirements
Module: sparse_syndrome_gen

Interface
REQ-001 SHALL have parameter R, default 127: code length, the width of every dense vector.
REQ-002 SHALL have parameter W, default 5: number of sparse positions per parity block.
REQ-003 SHALL have parameter POS_W, default 8: width of each sparse position field.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: request a computation; sampled only in IDLE.
REQ-007 SHALL have port c0_in, input, R bits: dense vector multiplied by h0.
REQ-008 SHALL have port c1_in, input, R bits: dense vector multiplied by h1; used only under SYND_DUAL_EN.
REQ-009 SHALL have port h0_pos_flat, input, W*POS_W bits: h0 positions, entry k at [k*POS_W +: POS_W].
REQ-010 SHALL have port h1_pos_flat, input, W*POS_W bits: h1 positions, same packing as h0_pos_flat.
REQ-011 SHALL have port s_out, output, R bits (registered): computed syndrome, ready to feed the bit-flipping decoder s_in.
REQ-012 SHALL have port s_zero, output, 1 bit (registered): 1 when s_out == 0 and done == 1.
REQ-013 SHALL have port busy, output, 1 bit: 1 while in LOAD or ACC.
REQ-014 SHALL have port done, output, 1 bit (registered): 1 while in DONE.
REQ-015 SHALL have port pos_err, output, 1 bit (registered): 1 when a position >= R was detected.

Function
REQ-016 SHALL compute s = XOR over k=0..W-1 of rotl(c0, h0_pos[k]), where rotl(x,p) bit j = x[(j-p) mod R]; input bit i lands at output bit (i+p) mod R.
REQ-017 SHALL use the FSM states IDLE, LOAD, ACC and DONE; any unused encoding SHALL go to IDLE.
REQ-018 In IDLE with start=1, SHALL register c0_in, c1_in and both position vectors, clear the accumulator, set k=0 and go to LOAD; while busy or done, SHALL ignore input changes.
REQ-019 In LOAD, SHALL check every registered position against R.
REQ-020 In LOAD, if any position >= R, SHALL set pos_err=1 and s_out=0 and go to DONE.
REQ-021 In LOAD, if all positions are in range, SHALL go to ACC.
REQ-022 In ACC, SHALL XOR exactly one rotated term per cycle for index k, increment k, and on k == W-1 load s_out with the final accumulator and go to DONE.
REQ-023 Latency SHALL be: done rises W+2 rising edges after the edge that samples start (pos_err path: 2 edges).
REQ-024 Rotation SHALL be a full R-bit variable rotate with no modulo operator; positions SHALL be in-range after the LOAD check.
REQ-025 Duplicate positions SHALL cancel by XOR.
REQ-026 Position 0 SHALL add the unrotated vector.
REQ-027 In DONE, done, s_out, s_zero and pos_err SHALL hold; the block SHALL return to IDLE on the first edge with start=0.
REQ-028 On the return from DONE to IDLE, done SHALL clear, and s_out and pos_err SHALL hold until the next start.
REQ-029 start held high through DONE SHALL NOT trigger a new computation until start is seen low.

Reset
REQ-030 On rst=1 at a rising edge, SHALL go to IDLE and set s_out=0, s_zero=0, done=0, pos_err=0, accumulator=0 and k=0; busy SHALL be 0.
REQ-031 Reset SHALL take priority over start and abort any computation in progress, with no partial result visible afterward.

Configuration
REQ-032 Macro SYND_DUAL_EN defined: ACC SHALL also XOR rotl(c1, h1_pos[k]) each cycle, so s = c0*h0 + c1*h1, and LOAD SHALL check h1 positions too.
REQ-033 Macro SYND_DUAL_EN undefined: c1_in and h1_pos_flat SHALL be ignored and s = c0*h0 only; latency SHALL be identical in both builds.

Verification (R=5, W=3)
REQ-034 SHALL cover: h0={0,1,4}, c0=00001, start pulse -> s_out=10011, done exactly W+2 edges after start.
REQ-035 SHALL cover: h0={0,1,4}, h1={1,2,3}, c0=01100, c1=00010 -> s_out=01110 with SYND_DUAL_EN, 10010 without.
REQ-036 SHALL cover: h0={2,2,3}, c0=00001 -> s_out=01000 (duplicate positions cancel).
REQ-037 SHALL cover: h0={0,5,1} -> pos_err=1, s_out=00000, done 2 edges after start.
REQ-038 SHALL cover: c0=00000 -> s_out=0, s_zero=1; start held high through DONE -> no restart until start drops.
REQ-039 SHALL cover: rst asserted during ACC -> next cycle IDLE, all outputs 0, then a fresh start completes correctly.
